// File: rtl/ntt_pkg.sv
// Shared constants, state type and zeta-index helpers for the 8-lane forward NTT sequencer.
// Walks n=256, q=3329 in 7 layers of 16 butterfly groups.
package ntt_pkg;

   localparam int unsigned NTT_N        = 256;
   localparam int unsigned NTT_LANES    = 8;
   localparam int unsigned NTT_LAYERS   = 7;
   localparam int unsigned NTT_GRPS     = 16;
   localparam int unsigned ZETA_ENTRIES = 18;

   localparam int unsigned LAYER_W = 3;
   localparam int unsigned GRP_W   = 4;
   localparam int unsigned ZIDX_W  = 5;
   localparam int unsigned LEN_W   = 8;

   localparam logic [LAYER_W-1:0] LAST_LAYER = 3'd6;
   localparam logic [GRP_W-1:0]   LAST_GRP   = 4'd15;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } ctrl_state_t;

   // First ROM entry used by each layer: {0,1,2,3,4,6,10}.
   function automatic logic [ZIDX_W-1:0] zbase(input logic [LAYER_W-1:0] layer);
      logic [ZIDX_W-1:0] b;
      b = '0;
      case (layer)
         3'd0:    b = 5'd0;
         3'd1:    b = 5'd1;
         3'd2:    b = 5'd2;
         3'd3:    b = 5'd3;
         3'd4:    b = 5'd4;
         3'd5:    b = 5'd6;
         3'd6:    b = 5'd10;
         default: b = 5'd0;
      endcase
      return b;
   endfunction

   // Number of groups sharing one ROM entry, as a shift: {4,4,4,4,3,2,1}.
   function automatic logic [2:0] zshift(input logic [LAYER_W-1:0] layer);
      logic [2:0] s;
      s = 3'd4;
      case (layer)
         3'd4:    s = 3'd3;
         3'd5:    s = 3'd2;
         3'd6:    s = 3'd1;
         default: s = 3'd4;
      endcase
      return s;
   endfunction

   function automatic logic [ZIDX_W-1:0] zeta_idx(input logic [LAYER_W-1:0] layer,
                                                  input logic [GRP_W-1:0]   grp);
      logic [ZIDX_W-1:0] g;
      g = {1'b0, grp} >> zshift(layer);
      return zbase(layer) + g;
   endfunction

endpackage

// File: rtl/ntt_delay_line.sv
// Enable-gated shift register carrying read-side tags to the write side of the butterfly pipe.
// Freezes completely while en_i is low; asynchronous reset clears every stage.
module ntt_delay_line #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [WIDTH-1:0] stage_d [DEPTH];

   always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         stage_d[i] = stage_q[i];
      end
      if (en_i) begin
         stage_d[0] = d_i;
         for (int i = 1; i < int'(DEPTH); i++) begin
            stage_d[i] = stage_q[i-1];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/ntt_layer_ctrl.sv
// Layer/group sequencer for the 8-lane forward NTT: issues reads, delayed write-backs,
// and drains the butterfly pipe between layers so no read overtakes a pending write.
module ntt_layer_ctrl
   import ntt_pkg::*;
#(
   parameter int unsigned PIPE_LAT = 4
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   input  logic               stall_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [LEN_W-1:0]   len_o,
   output logic [ZIDX_W-1:0]  zeta_idx_o,
   output logic               rd_en_o,
   output logic [GRP_W-1:0]   rd_grp_o,
   output logic [LAYER_W-1:0] rd_layer_o,
   output logic               wr_en_o,
   output logic [GRP_W-1:0]   wr_grp_o,
   output logic [LAYER_W-1:0] wr_layer_o
);

   localparam logic [3:0] DrainInit = 4'(PIPE_LAT);
   localparam int unsigned TagW = 1 + GRP_W + LAYER_W;

   ctrl_state_t        state_q, state_d;
   logic [GRP_W-1:0]   grp_q, grp_d;
   logic [LAYER_W-1:0] layer_q, layer_d;
   logic [3:0]         cnt_q, cnt_d;

   logic            rd_en;
   logic [TagW-1:0] wr_tag;

   always_comb begin
      state_d = state_q;
      grp_d   = grp_q;
      layer_d = layer_q;
      cnt_d   = cnt_q;
      if (!stall_i) begin
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  state_d = StRun;
                  grp_d   = '0;
                  layer_d = '0;
               end
            end
            StRun: begin
               if (grp_q == LAST_GRP) begin
                  state_d = StDrain;
                  cnt_d   = DrainInit;
               end else begin
                  grp_d = grp_q + 4'd1;
               end
            end
            StDrain: begin
               cnt_d = cnt_q - 4'd1;
               // cnt_q==1 is the cycle the layer's last write-back leaves the pipe.
               if (cnt_q <= 4'd1) begin
                  if (layer_q == LAST_LAYER) begin
                     state_d = StDone;
                  end else begin
                     state_d = StRun;
                     layer_d = layer_q + 3'd1;
                     grp_d   = '0;
                  end
               end
            end
            StDone: begin
               state_d = StIdle;
               grp_d   = '0;
               layer_d = '0;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         grp_q   <= '0;
         layer_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grp_q   <= grp_d;
         layer_q <= layer_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rd_en = (state_q == StRun) && !stall_i;

   ntt_delay_line #(
      .DEPTH (PIPE_LAT),
      .WIDTH (TagW)
   ) u_wr_delay (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (!stall_i),
      .d_i    ({rd_en, grp_q, layer_q}),
      .q_o    (wr_tag)
   );

   assign busy_o     = (state_q != StIdle);
   assign done_o     = (state_q == StDone) && !stall_i;
   assign len_o      = 8'd128 >> layer_q;
   assign zeta_idx_o = zeta_idx(layer_q, grp_q);
   assign rd_en_o    = rd_en;
   assign rd_grp_o   = grp_q;
   assign rd_layer_o = layer_q;
   assign wr_en_o    = wr_tag[TagW-1] && !stall_i;
   assign wr_grp_o   = wr_tag[GRP_W+LAYER_W-1:LAYER_W];
   assign wr_layer_o = wr_tag[LAYER_W-1:0];

endmodule

// File: tb/tb_ntt_layer_ctrl.sv
// Directed bench for ntt_layer_ctrl: full-run timing and zeta sequence, stall, start re-pulse,
// mid-run async reset, and done timing of PIPE_LAT=1 and 15 builds.
module tb_ntt_layer_ctrl;

   localparam int L   = 4;
   localparam int PER = 16 + L;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic stall = 1'b0;

   logic       busy, done, rd_en, wr_en;
   logic [7:0] len;
   logic [4:0] zeta;
   logic [3:0] rd_grp, wr_grp;
   logic [2:0] rd_layer, wr_layer;

   logic       a_busy, a_done, a_rd_en, a_wr_en;
   logic [7:0] a_len;
   logic [4:0] a_zeta;
   logic [3:0] a_rd_grp, a_wr_grp;
   logic [2:0] a_rd_layer, a_wr_layer;

   logic       b_busy, b_done, b_rd_en, b_wr_en;
   logic [7:0] b_len;
   logic [4:0] b_zeta;
   logic [3:0] b_rd_grp, b_wr_grp;
   logic [2:0] b_rd_layer, b_wr_layer;

   ntt_layer_ctrl #(.PIPE_LAT(L)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stall_i(stall),
      .busy_o(busy), .done_o(done), .len_o(len), .zeta_idx_o(zeta),
      .rd_en_o(rd_en), .rd_grp_o(rd_grp), .rd_layer_o(rd_layer),
      .wr_en_o(wr_en), .wr_grp_o(wr_grp), .wr_layer_o(wr_layer)
   );

   ntt_layer_ctrl #(.PIPE_LAT(1)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stall_i(stall),
      .busy_o(a_busy), .done_o(a_done), .len_o(a_len), .zeta_idx_o(a_zeta),
      .rd_en_o(a_rd_en), .rd_grp_o(a_rd_grp), .rd_layer_o(a_rd_layer),
      .wr_en_o(a_wr_en), .wr_grp_o(a_wr_grp), .wr_layer_o(a_wr_layer)
   );

   ntt_layer_ctrl #(.PIPE_LAT(15)) dut15 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stall_i(stall),
      .busy_o(b_busy), .done_o(b_done), .len_o(b_len), .zeta_idx_o(b_zeta),
      .rd_en_o(b_rd_en), .rd_grp_o(b_rd_grp), .rd_layer_o(b_rd_layer),
      .wr_en_o(b_wr_en), .wr_grp_o(b_wr_grp), .wr_layer_o(b_wr_layer)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   localparam logic [30:0] RESET_VEC =
      {1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 8'd128, 5'd0, 1'b0, 3'd0, 4'd0};

   function automatic logic [4:0] exp_zeta(input int k, input int g);
      case (k)
         0, 1, 2, 3: return 5'(k);
         4:          return 5'(4 + g / 8);
         5:          return 5'(6 + g / 4);
         6:          return 5'(10 + g / 2);
         default:    return 5'd0;
      endcase
   endfunction

   // Expected outputs at effective (un-stalled) cycle e after the start sample at cycle 0.
   function automatic logic [30:0] exp_vec(input int e, input bit stalled);
      int r, w;
      bit rd_ok, wr_ok, busy_e, done_e;
      logic [19:0] rdf;
      logic [6:0]  wrf;
      r      = e - 1;
      w      = e - 1 - L;
      rd_ok  = (e >= 1) && (e <= 7 * PER) && ((r % PER) < 16);
      wr_ok  = (w >= 0) && (w < 7 * PER) && ((w % PER) < 16);
      busy_e = (e >= 1) && (e <= 7 * PER + 1);
      done_e = (e == 7 * PER + 1) && !stalled;
      rdf    = rd_ok ? {3'(r / PER), 4'(r % PER), 8'(128 >> (r / PER)),
                        exp_zeta(r / PER, r % PER)} : 20'd0;
      wrf    = (wr_ok && !stalled) ? {3'(w / PER), 4'(w % PER)} : 7'd0;
      return {busy_e, done_e, rd_ok && !stalled, rdf, wr_ok && !stalled, wrf};
   endfunction

   function automatic logic [30:0] obs_vec(input bit stalled);
      logic [19:0] rdf;
      logic [6:0]  wrf;
      rdf = (rd_en || stalled) ? {rd_layer, rd_grp, len, zeta} : 20'd0;
      wrf = wr_en ? {wr_layer, wr_grp} : 7'd0;
      return {busy, done, rd_en, rdf, wr_en, wrf};
   endfunction

   function automatic logic [30:0] raw_vec();
      return {busy, done, rd_en, rd_layer, rd_grp, len, zeta, wr_en, wr_layer, wr_grp};
   endfunction

   task automatic chk(input string tag, input logic [30:0] obs, input logic [30:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      int n_rd, n_wr, n_done, a_at, a_n, b_at, b_n, e, late;
      bit stl;

      #2;
      chk("reset_state", raw_vec(), RESET_VEC);
      @(negedge clk);
      rst_n = 1'b1;

      // Full run, all three builds, with a start re-pulse mid-run that must be ignored.
      n_rd = 0; n_wr = 0; n_done = 0; a_at = 0; a_n = 0; b_at = 0; b_n = 0;
      next_cycle();
      cyc   = 0;
      start = 1'b1;
      next_cycle();
      start = 1'b0;
      while (cyc <= 225) begin
         start = (cyc == 50);
         #1;
         chk($sformatf("run_c%0d", cyc), obs_vec(1'b0), exp_vec(cyc, 1'b0));
         if (rd_en) n_rd++;
         if (wr_en) n_wr++;
         if (done) n_done++;
         if (a_done) begin
            if (a_at == 0) a_at = cyc;
            a_n++;
         end
         if (b_done) begin
            if (b_at == 0) b_at = cyc;
            b_n++;
         end
         next_cycle();
      end
      start = 1'b0;
      chk("rd_count", 31'(n_rd), 31'(112));
      chk("wr_count", 31'(n_wr), 31'(112));
      chk("done_pulses", 31'(n_done), 31'(1));
      chk("lat1_done_cycle", 31'(a_at), 31'(120));
      chk("lat1_done_pulses", 31'(a_n), 31'(1));
      chk("lat15_done_cycle", 31'(b_at), 31'(218));
      chk("lat15_done_pulses", 31'(b_n), 31'(1));
      chk("idle_after_run", 31'({busy, len, zeta, rd_grp, rd_layer}),
          31'({1'b0, 8'd128, 5'd0, 4'd0, 3'd0}));

      // Stall for cycles 68..72 (layer 3, group 7): frozen outputs, everything after slips by 5.
      cyc   = 0;
      start = 1'b1;
      next_cycle();
      start = 1'b0;
      late  = 0;
      while (cyc <= 160) begin
         stl   = (cyc >= 68) && (cyc <= 72);
         stall = stl;
         e     = (cyc < 68) ? cyc : (stl ? 68 : cyc - 5);
         #1;
         chk($sformatf("stall_c%0d", cyc), obs_vec(stl), exp_vec(e, stl));
         if (done) late = cyc;
         next_cycle();
      end
      stall = 1'b0;
      chk("stall_done_cycle", 31'(late), 31'(146));

      // Async reset in layer 5 drain: immediate reset values, no stray write-backs afterwards.
      cyc   = 0;
      start = 1'b1;
      next_cycle();
      start = 1'b0;
      while (cyc < 118) begin
         #1;
         chk($sformatf("pre_rst_c%0d", cyc), obs_vec(1'b0), exp_vec(cyc, 1'b0));
         next_cycle();
      end
      rst_n = 1'b0;
      #1;
      chk("async_reset", raw_vec(), RESET_VEC);
      next_cycle();
      rst_n = 1'b1;
      n_wr  = 0;
      n_rd  = 0;
      n_done = 0;
      repeat (30) begin
         #1;
         if (wr_en) n_wr++;
         if (rd_en || busy) n_rd++;
         if (done) n_done++;
         next_cycle();
      end
      chk("post_rst_wr", 31'(n_wr), 31'(0));
      chk("post_rst_active", 31'(n_rd + n_done), 31'(0));

      // Recovery: a fresh start begins again at layer 0, group 0.
      start = 1'b1;
      next_cycle();
      start = 1'b0;
      #1;
      chk("restart_first_read", 31'({busy, rd_en, rd_layer, rd_grp, len, zeta}),
          31'({1'b1, 1'b1, 3'd0, 4'd0, 8'd128, 5'd0}));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
